lsu_subword: RTL and testbench
==============================

Name: lsu_subword

Overview:
- Load/store unit that sits directly upstream of the data memory (dmem) in the uniciclo datapath.
- Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW, selected by funct3) into dmem's word-only interface.
- Loads: word-aligned read, then byte/half lane extraction with sign or zero extension.
- Sub-word stores: read-modify-write sequence, since dmem writes whole words only.
- Detects misaligned or illegal accesses and stalls the core until each access completes.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits. Fixed at 32; any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  core requests a memory access this cycle.
- we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  AW  byte address.
- wdata  input  DW  store data; the active lane is taken from the low bits.
- rdata  output  DW  extended load result; valid while done=1.
- done  output  1  one-cycle completion pulse.
- err  output  1  misaligned or illegal access; valid while done=1.
- stall  output  1  core must hold its PC and request.
- mem_we  output  1  dmem write enable.
- mem_a  output  AW  dmem byte address, always word-aligned ({addr[AW-1:2],2'b00}).
- mem_wd  output  DW  dmem write data.
- mem_rd  input  DW  dmem read data; combinational from mem_a.

Behaviour:
- State machine states: IDLE, WRITE, RESP.
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - rdata=0, done=0, err=0.
  - mem_we forced to 0 immediately, including mid-RMW.
  - Latched request registers cleared.
- IDLE:
  - stall = req. mem_a comes combinationally from the addr input.
  - On req, addr, funct3, we and wdata are latched.
- Legality check (in IDLE):
  - Illegal funct3: 011, 11x, or store with funct3 of BU/HU.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Either case: no memory activity (mem_we=0), then go to RESP with err=1 and rdata=0.
- Load (legal):
  - The lane of mem_rd selected by addr[1:0] is extracted.
  - B/H are sign-extended; BU/HU are zero-extended.
  - Result is registered into rdata; next state RESP.
  - Latency: done in cycle 1.
- SW (legal):
  - mem_we=1 and mem_wd=wdata in IDLE; dmem writes at the edge; next state RESP.
  - Latency: done in cycle 1.
- SB/SH (legal):
  - IDLE drives a read (mem_we=0).
  - At the edge, the merged word is latched: mem_rd with only the target byte/half replaced by wdata[7:0]/wdata[15:0] at lane addr[1:0]. Next state WRITE.
  - WRITE: stall=1, mem_we=1, mem_a from the latched address, mem_wd = merged word. Next state RESP.
  - Latency: done in cycle 2.
- RESP:
  - done=1, stall=0; rdata and err hold their values. Next state IDLE.
  - A req present in RESP is not accepted; it is taken in the following IDLE cycle.
- done, err and rdata:
  - done is high only in RESP.
  - err is cleared on the next accepted request.
  - rdata is held until the next accepted load or error.
- The addr, wdata and funct3 inputs may change after acceptance without effect.
- Byte order is little-endian: lane 0 = bits [7:0].
- No wrap-around concern: address arithmetic is lane selection only; no incrementing.

Test Plan:
- Memory model word @0x3E8 = 0x80818283.
  - LB 0x3E8 → rdata=0xFFFFFF83, done in cycle 1, err=0.
  - LBU 0x3E9 → rdata=0x00000082.
  - LH 0x3EA → rdata=0xFFFF8081.
  - LHU 0x3EA → rdata=0x00008081.
- SB 0x3E9, wdata=0x123456AA:
  - Cycle 0 mem_we=0; cycle 1 mem_we=1, mem_wd=0x8081AA83; cycle 2 done.
  - Follow-up LW 0x3E8 → 0x8081AA83.
- SW 0x3F0, wdata=0xDEADBEEF → mem_we=1 in cycle 0, done in cycle 1; LW 0x3F0 → 0xDEADBEEF.
- Error cases: LW 0x3EA, SH 0x3E9, and funct3=011 each give err=1, rdata=0, done in cycle 1, and mem_we stays 0 throughout.
- Reset mid-operation: assert rst=0 during the WRITE cycle of an SH →
  - mem_we drops to 0 immediately; memory word is unchanged.
  - After release: state IDLE, done=0, stall=0 with req=0.
- Back-to-back: req held high across LW, then SB, then LW.
  - Each access completes exactly once with correct data.
  - No request is accepted in a RESP cycle.

Source files
------------

// File: rtl/lsu_subword_if.sv
// Core-side request/response and dmem bus for lsu_subword.
// master drives requests and memory read data; slave is the LSU.
interface lsu_subword_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;
  logic          err;
  logic          stall;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport master (
    output req, we, funct3, addr, wdata, mem_rd,
    input  rdata, done, err, stall,
    input  mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rd,
    output rdata, done, err, stall,
    output mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_subword.sv
// RV32I load/store adapter in front of a word-only dmem.
// Sub-word stores go through a read-modify-write sequence.
module lsu_subword #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst,
  lsu_subword_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } state_t;

  state_t        st;
  logic [AW-3:0] wa_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rd_q;
  logic          err_q;

  logic [2:0]    f3;
  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          sx;
  logic          bad_f3;
  logic          misal;
  logic          bad;
  logic [DW-1:0] lane;
  logic [DW-1:0] ld_val;
  logic [DW-1:0] merged;

  assign f3     = bus.funct3;
  assign is_b   = f3[1:0] == 2'b00;
  assign is_h   = f3[1:0] == 2'b01;
  assign is_w   = f3 == 3'b010;
  assign sx     = ~f3[2];
  assign bad_f3 = (f3 == 3'b011)
                | (f3[2:1] == 2'b11)
                | (bus.we & f3[2]);
  assign misal  = (is_h & bus.addr[0])
                | (is_w & |bus.addr[1:0]);
  assign bad    = bad_f3 | misal;

  assign lane = bus.mem_rd >> {bus.addr[1:0], 3'b000};

  always_comb begin
    ld_val = lane;
    unique case (1'b1)
      is_w: ld_val = bus.mem_rd;
      is_b: ld_val = {{(DW-8){sx & lane[7]}},
                      lane[7:0]};
      default: ld_val = {{(DW-16){sx & lane[15]}},
                         lane[15:0]};
    endcase
  end

  // Only the addressed lane of the current word is replaced.
  always_comb begin
    merged = bus.mem_rd;
    if (is_b)
      merged[{bus.addr[1:0], 3'b000} +: 8] =
        bus.wdata[7:0];
    else
      merged[{bus.addr[1], 4'b0000} +: 16] =
        bus.wdata[15:0];
  end

  always_comb begin
    bus.stall  = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_a  = {bus.addr[AW-1:2], 2'b00};
    bus.mem_wd = bus.wdata;
    unique case (st)
      IDLE: begin
        bus.stall  = bus.req;
        bus.mem_we = bus.req & bus.we
                   & is_w & ~bad;
      end
      WRITE: begin
        bus.stall  = 1'b1;
        bus.mem_we = 1'b1;
        bus.mem_a  = {wa_q, 2'b00};
        bus.mem_wd = wd_q;
      end
      default: ;
    endcase
    // Write enable must fall with reset, not wait for a clock.
    if (!rst) bus.mem_we = 1'b0;
  end

  assign bus.done  = st == RESP;
  assign bus.rdata = rd_q;
  assign bus.err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= IDLE;
      wa_q  <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.req) begin
            wa_q  <= bus.addr[AW-1:2];
            err_q <= bad;
            st    <= RESP;
            if (bad) begin
              rd_q <= '0;
            end else if (!bus.we) begin
              rd_q <= ld_val;
            end else if (!is_w) begin
              wd_q <= merged;
              st   <= WRITE;
            end
          end
        end
        WRITE:   st <= RESP;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a word-wide dmem model.
// Each scenario task drives its vectors and checks them inline.
module tb_lsu_subword;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [31:0] mem [0:1023];

  lsu_subword_if #(.AW(32), .DW(32)) bus ();

  lsu_subword #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[11:2]];

  always @(posedge clk)
    if (bus.mem_we) mem[bus.mem_a[11:2]] <= bus.mem_wd;

  task automatic drive(input logic r, input logic w,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] d);
    bus.req    = r;
    bus.we     = w;
    bus.funct3 = f;
    bus.addr   = a;
    bus.wdata  = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata got %h want 0", bus.rdata);
    end
    n_cmp++;
    if ({bus.done, bus.err, bus.mem_we, bus.stall} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.done, bus.err, bus.mem_we, bus.stall});
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_done got %b want 0", bus.done);
    end
    step();
  endtask

  task automatic test_loads;
    logic [2:0]  f [4];
    logic [31:0] a [4];
    logic [31:0] e [4];
    f[0] = 3'b000; a[0] = 32'h3E8; e[0] = 32'hFFFF_FF83;
    f[1] = 3'b100; a[1] = 32'h3E9; e[1] = 32'h0000_0082;
    f[2] = 3'b001; a[2] = 32'h3EA; e[2] = 32'hFFFF_8081;
    f[3] = 3'b101; a[3] = 32'h3EA; e[3] = 32'h0000_8081;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, f[i], a[i], 32'h0);
      @(negedge clk);
      n_cmp++;
      if ({bus.stall, bus.mem_we, bus.done} !== 3'b100) begin
        n_bad++;
        $display("FAIL load%0d_c0 got %b want 100", i,
                 {bus.stall, bus.mem_we, bus.done});
      end
      step();
      bus.req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.done, bus.err} !== 2'b10) begin
        n_bad++;
        $display("FAIL load%0d_done got %b want 10", i,
                 {bus.done, bus.err});
      end
      n_cmp++;
      if (bus.rdata !== e[i]) begin
        n_bad++;
        $display("FAIL load%0d_rdata got %h want %h", i,
                 bus.rdata, e[i]);
      end
      step();
    end
  endtask

  task automatic test_sb;
    drive(1'b1, 1'b1, 3'b000, 32'h3E9, 32'h1234_56AA);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_we, bus.stall} !== 2'b01) begin
      n_bad++;
      $display("FAIL sb_c0 got %b want 01",
               {bus.mem_we, bus.stall});
    end
    step();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_we, bus.stall, bus.done} !== 3'b110) begin
      n_bad++;
      $display("FAIL sb_c1 got %b want 110",
               {bus.mem_we, bus.stall, bus.done});
    end
    n_cmp++;
    if (bus.mem_wd !== 32'h8081_AA83 || bus.mem_a !== 32'h3E8) begin
      n_bad++;
      $display("FAIL sb_wd got %h@%h want 8081aa83@3e8",
               bus.mem_wd, bus.mem_a);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.err, bus.mem_we} !== 3'b100) begin
      n_bad++;
      $display("FAIL sb_done got %b want 100",
               {bus.done, bus.err, bus.mem_we});
    end
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h3E8, 32'h0);
    step();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'h8081_AA83) begin
      n_bad++;
      $display("FAIL sb_lw got %b/%h want 1/8081aa83",
               bus.done, bus.rdata);
    end
    step();
  endtask

  task automatic test_sw;
    drive(1'b1, 1'b1, 3'b010, 32'h3F0, 32'hDEAD_BEEF);
    @(negedge clk);
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL sw_c0 got %b/%h want 1/deadbeef",
               bus.mem_we, bus.mem_wd);
    end
    step();
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.err, bus.mem_we} !== 3'b100) begin
      n_bad++;
      $display("FAIL sw_done got %b want 100",
               {bus.done, bus.err, bus.mem_we});
    end
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h3F0, 32'h0);
    step();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL sw_lw got %b/%h want 1/deadbeef",
               bus.done, bus.rdata);
    end
    step();
  endtask

  task automatic test_errors;
    logic        w [3];
    logic [2:0]  f [3];
    logic [31:0] a [3];
    w[0] = 1'b0; f[0] = 3'b010; a[0] = 32'h3EA;
    w[1] = 1'b1; f[1] = 3'b001; a[1] = 32'h3E9;
    w[2] = 1'b0; f[2] = 3'b011; a[2] = 32'h3E8;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w[i], f[i], a[i], 32'hFFFF_FFFF);
      @(negedge clk);
      n_cmp++;
      if (bus.mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL err%0d_we0 got %b want 0", i, bus.mem_we);
      end
      step();
      bus.req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.done, bus.err, bus.mem_we} !== 3'b110) begin
        n_bad++;
        $display("FAIL err%0d_resp got %b want 110", i,
                 {bus.done, bus.err, bus.mem_we});
      end
      n_cmp++;
      if (bus.rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL err%0d_rdata got %h want 0", i, bus.rdata);
      end
      step();
    end
    n_cmp++;
    if (mem[250] !== 32'h8081_AA83) begin
      n_bad++;
      $display("FAIL err_mem got %h want 8081aa83", mem[250]);
    end
    drive(1'b1, 1'b0, 3'b100, 32'h3E8, 32'h0);
    step();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.err} !== 2'b10 || bus.rdata !== 32'h83) begin
      n_bad++;
      $display("FAIL err_clear got %b/%h want 10/00000083",
               {bus.done, bus.err}, bus.rdata);
    end
    step();
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 3'b001, 32'h3EC, 32'h0000_BEEF);
    step();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_write got %b want 1", bus.mem_we);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_we_drop got %b want 0", bus.mem_we);
    end
    step();
    n_cmp++;
    if (mem[251] !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL rmid_mem got %h want 11223344", mem[251]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.stall, bus.mem_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid_idle got %b want 000",
               {bus.done, bus.stall, bus.mem_we});
    end
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h3EC, 32'h0);
    step();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'h1122_3344) begin
      n_bad++;
      $display("FAIL rmid_lw got %b/%h want 1/11223344",
               bus.done, bus.rdata);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    drive(1'b1, 1'b0, 3'b010, 32'h3F0, 32'h0);
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if ({bus.stall, bus.done} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_c0 got %b want 10", {bus.stall, bus.done});
    end
    step();
    drive(1'b1, 1'b1, 3'b000, 32'h3F3, 32'h0000_0077);
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if ({bus.done, bus.stall, bus.mem_we} !== 3'b100 ||
        bus.rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL b2b_c1 got %b/%h want 100/deadbeef",
               {bus.done, bus.stall, bus.mem_we}, bus.rdata);
    end
    step();
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if ({bus.done, bus.stall, bus.mem_we} !== 3'b010) begin
      n_bad++;
      $display("FAIL b2b_c2 got %b want 010",
               {bus.done, bus.stall, bus.mem_we});
    end
    step();
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'h77AD_BEEF) begin
      n_bad++;
      $display("FAIL b2b_c3 got %b/%h want 1/77adbeef",
               bus.mem_we, bus.mem_wd);
    end
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h3F0, 32'h0);
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL b2b_c4 got %b/%h want 1/deadbeef",
               bus.done, bus.rdata);
    end
    step();
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if ({bus.done, bus.stall} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_c5 got %b want 01", {bus.done, bus.stall});
    end
    step();
    bus.req = 1'b0;
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'h77AD_BEEF) begin
      n_bad++;
      $display("FAIL b2b_c6 got %b/%h want 1/77adbeef",
               bus.done, bus.rdata);
    end
    step();
    @(negedge clk);
    pulses += int'(bus.done);
    n_cmp++;
    if (pulses !== 3) begin
      n_bad++;
      $display("FAIL b2b_pulses got %0d want 3", pulses);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[250] = 32'h8081_8283;
    mem[251] = 32'h1122_3344;
    test_reset();
    test_loads();
    test_sb();
    test_sw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
